// File: rtl/lcd_frame_driver.sv
// lcd_frame_driver
//   Drives a 16x2 HD44780-compatible LCD in 8-bit parallel mode from the
//   256-bit frame exported by the RAM. After reset the block waits out the
//   LCD power-up time and runs the init sequence once. It then redraws the
//   whole screen continuously. Each frame is drawn from a snapshot of
//   lcd_frame taken at frame start.
//
// Ports
//   clk         system clock
//   nrst        asynchronous active-low reset
//   lcd_frame   char i = lcd_frame[8i+7:8i]; chars 0..15 row 0, 16..31 row 1
//   lcd_en      LCD enable strobe
//   lcd_rs      0 = command, 1 = character data
//   lcd_rw      tied 0 (write only)
//   lcd_data    LCD data bus
//   init_done   high from the end of the init sequence until reset
//   frame_done  one-cycle pulse after the last character of each frame
//
// state       | meaning
// ------------+-----------------------------------------------------------
// POWER_WAIT  | idle for POWERUP_CYCLES after reset
// INIT        | write 0x38, 0x0C, 0x01 (long wait), 0x06
// FRAME_START | capture lcd_frame into the snapshot, reset char index
// ADDR0       | write DDRAM address 0x80 (row 0)
// ROW0        | write chars 0..15
// ADDR1       | write DDRAM address 0xC0 (row 1)
// ROW1        | write chars 16..31
// FRAME_END   | pulse frame_done

module lcd_frame_driver #(
  parameter int POWERUP_CYCLES    = 150000,
  parameter int EN_HIGH_CYCLES    = 5,
  parameter int CMD_WAIT_CYCLES   = 400,
  parameter int CLEAR_WAIT_CYCLES = 16000
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic [255:0] lcd_frame,
  output logic         lcd_en,
  output logic         lcd_rs,
  output logic         lcd_rw,
  output logic [7:0]   lcd_data,
  output logic         init_done,
  output logic         frame_done
);

  localparam int MAX_AB = (POWERUP_CYCLES > EN_HIGH_CYCLES) ? POWERUP_CYCLES : EN_HIGH_CYCLES;
  localparam int MAX_CD = (CMD_WAIT_CYCLES > CLEAR_WAIT_CYCLES) ? CMD_WAIT_CYCLES : CLEAR_WAIT_CYCLES;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int TW     = $clog2(MAX_P + 1);

  typedef enum logic [2:0] {
    ST_POWER_WAIT, ST_INIT, ST_FRAME_START, ST_ADDR0,
    ST_ROW0, ST_ADDR1, ST_ROW1, ST_FRAME_END
  } state_t;

  // PH_IDLE only occurs on entry to INIT, giving one spare cycle after power-up.
  typedef enum logic [1:0] {PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD} phase_t;

  state_t         state, state_nxt;
  phase_t         phase, phase_nxt;
  logic [TW-1:0]  tmr, tmr_nxt;
  logic [4:0]     idx, idx_nxt;
  logic [1:0]     step, step_nxt;
  logic           init_done_nxt;
  logic           snap_ld;
  logic [255:0]   snap;
  logic [7:0]     init_cmd;
  logic [7:0]     snap_byte;
  logic [7:0]     char_out;
  logic [TW-1:0]  hold_load;
  logic           in_write;

  always_comb begin
    case (step)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h01;
      default: init_cmd = 8'h06;
    endcase
  end

  assign snap_byte = snap[{idx, 3'b000} +: 8];
  assign char_out  = (snap_byte == 8'h00) ? 8'h20 : snap_byte;

  // The clear command (third init write) needs the long settle time.
  assign hold_load = (state == ST_INIT && step == 2'd2) ? TW'(CLEAR_WAIT_CYCLES - 1)
                                                        : TW'(CMD_WAIT_CYCLES - 1);

  assign in_write = (state == ST_INIT) || (state == ST_ADDR0) || (state == ST_ROW0) ||
                    (state == ST_ADDR1) || (state == ST_ROW1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= ST_POWER_WAIT;
      phase     <= PH_IDLE;
      tmr       <= '0;
      idx       <= '0;
      step      <= '0;
      init_done <= 1'b0;
      snap      <= '0;
    end else begin
      state     <= state_nxt;
      phase     <= phase_nxt;
      tmr       <= tmr_nxt;
      idx       <= idx_nxt;
      step      <= step_nxt;
      init_done <= init_done_nxt;
      if (snap_ld) snap <= lcd_frame;
    end
  end

  always_comb begin
    state_nxt     = state;
    phase_nxt     = phase;
    tmr_nxt       = tmr;
    idx_nxt       = idx;
    step_nxt      = step;
    init_done_nxt = init_done;
    snap_ld       = 1'b0;
    case (state)
      ST_POWER_WAIT: begin
        if (tmr == TW'(POWERUP_CYCLES - 1)) begin
          state_nxt = ST_INIT;
          phase_nxt = PH_IDLE;
          tmr_nxt   = '0;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      ST_FRAME_START: begin
        snap_ld   = 1'b1;
        idx_nxt   = '0;
        state_nxt = ST_ADDR0;
        phase_nxt = PH_SETUP;
      end
      ST_FRAME_END: state_nxt = ST_FRAME_START;
      default: begin
        case (phase)
          PH_IDLE:  phase_nxt = PH_SETUP;
          PH_SETUP: begin
            phase_nxt = PH_STROBE;
            tmr_nxt   = TW'(EN_HIGH_CYCLES - 1);
          end
          PH_STROBE: begin
            if (tmr == '0) begin
              phase_nxt = PH_HOLD;
              tmr_nxt   = hold_load;
            end else begin
              tmr_nxt = tmr - 1'b1;
            end
          end
          default: begin
            if (tmr != '0) begin
              tmr_nxt = tmr - 1'b1;
            end else begin
              // Last HOLD cycle: the next write's SETUP follows immediately.
              phase_nxt = PH_SETUP;
              case (state)
                ST_INIT: begin
                  if (step == 2'd3) begin
                    state_nxt     = ST_FRAME_START;
                    init_done_nxt = 1'b1;
                    step_nxt      = '0;
                  end else begin
                    step_nxt = step + 1'b1;
                  end
                end
                ST_ADDR0: state_nxt = ST_ROW0;
                ST_ROW0: begin
                  idx_nxt = idx + 1'b1;
                  if (idx == 5'd15) state_nxt = ST_ADDR1;
                end
                ST_ADDR1: state_nxt = ST_ROW1;
                default: begin
                  // ROW1: index stays at 31 here; FRAME_START rewinds it.
                  if (idx == 5'd31) state_nxt = ST_FRAME_END;
                  else              idx_nxt   = idx + 1'b1;
                end
              endcase
            end
          end
        endcase
      end
    endcase
  end

  always_comb begin
    lcd_rw     = 1'b0;
    lcd_rs     = 1'b0;
    lcd_data   = 8'h00;
    lcd_en     = in_write && (phase == PH_STROBE);
    frame_done = (state == ST_FRAME_END);
    if (in_write && phase != PH_IDLE) begin
      case (state)
        ST_INIT:  lcd_data = init_cmd;
        ST_ADDR0: lcd_data = 8'h80;
        ST_ADDR1: lcd_data = 8'hC0;
        default: begin
          lcd_rs   = 1'b1;
          lcd_data = char_out;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_driver.sv
module tb_lcd_frame_driver;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic [255:0] lcd_frame = '0;
  logic         lcd_en, lcd_rs, lcd_rw, init_done, frame_done;
  logic [7:0]   lcd_data;

  always #5 clk = ~clk;

  lcd_frame_driver #(
    .POWERUP_CYCLES(10),
    .EN_HIGH_CYCLES(2),
    .CMD_WAIT_CYCLES(4),
    .CLEAR_WAIT_CYCLES(8)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .lcd_frame(lcd_frame),
    .lcd_en(lcd_en),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_data(lcd_data),
    .init_done(init_done),
    .frame_done(frame_done)
  );

  typedef struct {
    bit         is_fd;
    bit         rs;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_rise  = 0;
  int   n_fd    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_w(input bit rs, input logic [7:0] d, input int gap);
    exp_t e;
    e.is_fd = 1'b0; e.rs = rs; e.data = d; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic push_fd();
    exp_t e;
    e.is_fd = 1'b1; e.rs = 1'b0; e.data = 8'h00; e.gap = 0;
    exp_q.push_back(e);
  endtask

  task automatic push_init();
    push_w(1'b0, 8'h38, 12);
    push_w(1'b0, 8'h0C, 7);
    push_w(1'b0, 8'h01, 7);
    push_w(1'b0, 8'h06, 11);
  endtask

  // exp_chars holds the bytes expected on the bus, written out by hand.
  task automatic push_frame(input logic [255:0] exp_chars, input int first_gap, input int n_chars);
    push_w(1'b0, 8'h80, first_gap);
    for (int i = 0; i < n_chars; i++) begin
      if (i == 16) push_w(1'b0, 8'hC0, 7);
      push_w(1'b1, exp_chars[8*i +: 8], 7);
    end
    if (n_chars == 32) push_fd();
  endtask

  // Monitor / scoreboard, sampling 1 time unit after each rising edge.
  int         cyc = 0;
  int         rel_cyc = 0;
  int         last_rise = 0;
  int         last_fd = -1;
  logic       nrst_q = 1'b0, en_q = 1'b0, init_q = 1'b0, fd_q = 1'b0, rs_q = 1'b0;
  logic [7:0] data_q = 8'h00;

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    if (!nrst) begin
      chk("reset_outputs", {26'd0, lcd_en, lcd_rs, lcd_rw, init_done, frame_done, |lcd_data}, 32'd0);
      last_fd = -1;
    end else begin
      if (!nrst_q) begin
        rel_cyc   = cyc - 1;
        last_rise = rel_cyc;
      end
      if (cyc - rel_cyc <= 10)
        chk("power_wait_outputs", {16'd0, lcd_en, lcd_rs, lcd_rw, init_done, frame_done, 3'd0, lcd_data}, 32'd0);
      chk("lcd_rw", {31'd0, lcd_rw}, 32'd0);
      if (lcd_en && !en_q) begin
        n_rise++;
        chk("setup_stable", {23'd0, rs_q, data_q}, {23'd0, lcd_rs, lcd_data});
        if (exp_q.size() == 0) begin
          chk("unexpected_write", {23'd0, lcd_rs, lcd_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("kind_write", {31'd0, e.is_fd}, 32'd0);
          chk("write_rs", {31'd0, lcd_rs}, {31'd0, e.rs});
          chk("write_data", {24'd0, lcd_data}, {24'd0, e.data});
          chk("write_gap", cyc - last_rise, e.gap);
        end
        last_rise = cyc;
      end
      if (init_done && !init_q)
        chk("init_done_timing", cyc - last_rise, 32'd6);
      if (init_q)
        chk("init_done_held", {31'd0, init_done}, 32'd1);
      if (frame_done) begin
        n_fd++;
        chk("frame_done_width", {31'd0, fd_q}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_frame_done", 32'd0, 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("kind_frame_done", {31'd0, e.is_fd}, 32'd1);
        end
        if (last_fd >= 0) chk("frame_period", cyc - last_fd, 32'd240);
        last_fd = cyc;
      end
    end
    nrst_q = nrst;
    en_q   = lcd_en;
    init_q = init_done;
    fd_q   = frame_done;
    rs_q   = lcd_rs;
    data_q = lcd_data;
  end

  task automatic wait_rise(input int target);
    int budget = 3000;
    while (n_rise < target && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (n_rise < target) chk("timeout_rise", n_rise, target);
  endtask

  task automatic wait_fd(input int target);
    int budget = 3000;
    while (n_fd < target && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    if (n_fd < target) chk("timeout_frame_done", n_fd, target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  logic [255:0] frame_a, exp_a, exp_z;

  initial begin
    for (int i = 0; i < 32; i++) begin
      frame_a[8*i +: 8] = (i == 5) ? 8'h00 : 8'(8'h41 + i);
      exp_a[8*i +: 8]   = (i == 5) ? 8'h20 : 8'(8'h41 + i);
      exp_z[8*i +: 8]   = 8'h7A;
    end
    lcd_frame = frame_a;

    // Init, frames 1-2 with pattern A, frame 3 after the mid-frame change,
    // and frame 4 cut short by reset at char 20.
    push_init();
    push_frame(exp_a, 8, 32);
    push_frame(exp_a, 9, 32);
    push_frame(exp_z, 9, 32);
    push_frame(exp_z, 9, 21);

    repeat (3) @(negedge clk);
    nrst = 1'b1;

    // Rise 45 is char 5 of frame 2 (row 0).
    wait_rise(45);
    lcd_frame = {32{8'h7A}};

    // Rise 129 is char 20 of frame 4; reset lands inside its strobe.
    wait_rise(129);
    chk("strobe_before_reset", {31'd0, lcd_en}, 32'd1);
    nrst = 1'b0;
    #1;
    chk("reset_en_drop", {31'd0, lcd_en}, 32'd0);
    chk("reset_init_done_drop", {31'd0, init_done}, 32'd0);
    chk("queue_empty_at_reset", exp_q.size(), 32'd0);

    push_init();
    push_frame(exp_z, 8, 32);
    repeat (2) @(negedge clk);
    nrst = 1'b1;

    wait_fd(4);
    chk("queue_empty_at_end", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
